spi_tft_fill_ctrl: RTL and testbench

- Top-level sequencer for the SPI TFT panel. Owns the single SPI byte transmitter.
- After reset it runs the panel init module to completion, then accepts rectangle-fill requests.
- Each fill issues CASET/RASET/RAMWR plus a solid RGB565 pixel stream.
- Muxes the init module and its own fill engine onto one byte-level SPI request/ack interface.

---
 rtl/spi_tft_pkg.sv | 30 +++
 rtl/spi_tft_fill_ctrl_if.sv | 25 ++
 rtl/spi_tft_win_cmd_rom.sv | 32 +++
 rtl/spi_tft_fill_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_spi_tft_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_tft_pkg.sv
// Shared types and constants for the SPI TFT panel sequencer:
// FSM state encoding, window command opcodes and D/C levels.
package spi_tft_pkg;

   typedef enum logic [6:0] {
      S_INIT_REQ = 7'b000_0001,
      S_INIT     = 7'b000_0010,
      S_IDLE     = 7'b000_0100,
      S_CMD      = 7'b000_1000,
      S_PIXEL    = 7'b001_0000,
      S_END      = 7'b010_0000,
      S_DONE     = 7'b100_0000
   } fill_state_e;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // Window sequence is 11 bytes long; index 10 is the RAMWR opcode.
   localparam logic [3:0] WIN_LAST_IDX = 4'd10;

   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } spi_byte_t;

endpackage

// File: rtl/spi_tft_fill_ctrl_if.sv
// Byte-level SPI request/ack bus between the fill sequencer and the
// single SPI byte transmitter.
interface spi_tft_fill_ctrl_if;
   logic       spi_req;
   logic [7:0] spi_data;
   logic       spi_dc;
   logic       spi_end;
   logic       spi_ack;

   modport master (
      output spi_req,
      output spi_data,
      output spi_dc,
      output spi_end,
      input  spi_ack
   );

   modport slave (
      input  spi_req,
      input  spi_data,
      input  spi_dc,
      input  spi_end,
      output spi_ack
   );
endinterface

// File: rtl/spi_tft_win_cmd_rom.sv
// Combinational lookup of the 11-byte address-window sequence:
// CASET x0 x1, RASET y0 y1, RAMWR, each coordinate sent MSB first.
module spi_tft_win_cmd_rom
   import spi_tft_pkg::*;
(
   input  logic [3:0]  idx_i,
   input  logic [15:0] x0_i,
   input  logic [15:0] x1_i,
   input  logic [15:0] y0_i,
   input  logic [15:0] y1_i,
   output spi_byte_t   byte_o
);

   always_comb begin
      byte_o = '{dc: DC_CMD, data: 8'h00};
      case (idx_i)
         4'd0:    byte_o = '{dc: DC_CMD,  data: CMD_CASET};
         4'd1:    byte_o = '{dc: DC_DATA, data: x0_i[15:8]};
         4'd2:    byte_o = '{dc: DC_DATA, data: x0_i[7:0]};
         4'd3:    byte_o = '{dc: DC_DATA, data: x1_i[15:8]};
         4'd4:    byte_o = '{dc: DC_DATA, data: x1_i[7:0]};
         4'd5:    byte_o = '{dc: DC_CMD,  data: CMD_RASET};
         4'd6:    byte_o = '{dc: DC_DATA, data: y0_i[15:8]};
         4'd7:    byte_o = '{dc: DC_DATA, data: y0_i[7:0]};
         4'd8:    byte_o = '{dc: DC_DATA, data: y1_i[15:8]};
         4'd9:    byte_o = '{dc: DC_DATA, data: y1_i[7:0]};
         4'd10:   byte_o = '{dc: DC_CMD,  data: CMD_RAMWR};
         default: byte_o = '{dc: DC_CMD,  data: 8'h00};
      endcase
   end

endmodule

// File: rtl/spi_tft_fill_ctrl.sv
// Panel sequencer: runs the init module once after reset, then turns
// clipped rectangle-fill requests into window commands plus a solid RGB565 stream.
module spi_tft_fill_ctrl
   import spi_tft_pkg::*;
#(
   parameter logic [15:0] SCREEN_WIDTH  = 16'd320,
   parameter logic [15:0] SCREEN_HEIGHT = 16'd240,
   parameter int unsigned PIX_CNT_W     = 18
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,

   output logic        init_req_o,
   input  logic        init_ack_i,
   input  logic [7:0]  init_data_i,
   input  logic        init_dc_i,
   input  logic        init_spi_req_i,
   input  logic        init_spi_end_i,
   output logic        init_spi_ack_o,

   input  logic        fill_req_i,
   input  logic [15:0] fill_x0_i,
   input  logic [15:0] fill_x1_i,
   input  logic [15:0] fill_y0_i,
   input  logic [15:0] fill_y1_i,
   input  logic [15:0] fill_color_i,
   output logic        ready_o,
   output logic        fill_done_o,
   output logic        fill_err_o,

   spi_tft_fill_ctrl_if.master spi
);

   fill_state_e          state_q, state_d;
   logic                 init_req_q, init_req_d;
   logic [15:0]          x0_q, x0_d;
   logic [15:0]          x1c_q, x1c_d;
   logic [15:0]          y0_q, y0_d;
   logic [15:0]          y1c_q, y1c_d;
   logic [15:0]          color_q, color_d;
   logic                 err_q, err_d;
   logic [3:0]           idx_q, idx_d;
   logic                 phase_q, phase_d;
   logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;

   logic [15:0]          x1_clip, y1_clip;
   logic                 reject;
   logic [PIX_CNT_W-1:0] win_w, win_h, pix_total;
   spi_byte_t            rom_byte;

   logic                 spi_req, spi_dc, spi_end;
   logic [7:0]           spi_data;

   spi_tft_win_cmd_rom u_win_cmd_rom (
      .idx_i  (idx_q),
      .x0_i   (x0_q),
      .x1_i   (x1c_q),
      .y0_i   (y0_q),
      .y1_i   (y1c_q),
      .byte_o (rom_byte)
   );

   always_comb begin
      x1_clip = (fill_x1_i > SCREEN_WIDTH - 16'd1)  ? SCREEN_WIDTH - 16'd1  : fill_x1_i;
      y1_clip = (fill_y1_i > SCREEN_HEIGHT - 16'd1) ? SCREEN_HEIGHT - 16'd1 : fill_y1_i;
      reject  = (fill_x0_i > x1_clip) || (fill_y0_i > y1_clip) ||
                (fill_x0_i >= SCREEN_WIDTH) || (fill_y0_i >= SCREEN_HEIGHT);
      win_w     = PIX_CNT_W'(x1c_q - x0_q) + PIX_CNT_W'(1);
      win_h     = PIX_CNT_W'(y1c_q - y0_q) + PIX_CNT_W'(1);
      pix_total = win_w * win_h;
   end

   always_comb begin
      state_d        = state_q;
      init_req_d     = 1'b0;
      x0_d           = x0_q;
      x1c_d          = x1c_q;
      y0_d           = y0_q;
      y1c_d          = y1c_q;
      color_d        = color_q;
      err_d          = err_q;
      idx_d          = idx_q;
      phase_d        = phase_q;
      pix_cnt_d      = pix_cnt_q;
      ready_o        = 1'b0;
      fill_done_o    = 1'b0;
      fill_err_o     = 1'b0;
      init_spi_ack_o = 1'b0;
      spi_req        = 1'b0;
      spi_data       = 8'h00;
      spi_dc         = DC_CMD;
      spi_end        = 1'b0;

      case (state_q)
         // init_req is registered so it stays low while reset is held;
         // the init module therefore sees it on the first S_INIT cycle.
         S_INIT_REQ: begin
            init_req_d = 1'b1;
            state_d    = S_INIT;
         end
         S_INIT: begin
            spi_req        = init_spi_req_i;
            spi_data       = init_data_i;
            spi_dc         = init_dc_i;
            spi_end        = init_spi_end_i;
            init_spi_ack_o = spi.spi_ack;
            if (init_ack_i) state_d = S_IDLE;
         end
         S_IDLE: begin
            ready_o = 1'b1;
            if (fill_req_i) begin
               x0_d    = fill_x0_i;
               x1c_d   = x1_clip;
               y0_d    = fill_y0_i;
               y1c_d   = y1_clip;
               color_d = fill_color_i;
               idx_d   = '0;
               err_d   = reject;
               state_d = reject ? S_DONE : S_CMD;
            end
         end
         S_CMD: begin
            spi_req  = 1'b1;
            spi_data = rom_byte.data;
            spi_dc   = rom_byte.dc;
            if (spi.spi_ack) begin
               if (idx_q == WIN_LAST_IDX) begin
                  pix_cnt_d = pix_total;
                  phase_d   = 1'b0;
                  state_d   = S_PIXEL;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_PIXEL: begin
            spi_req  = 1'b1;
            spi_dc   = DC_DATA;
            spi_data = phase_q ? color_q[7:0] : color_q[15:8];
            if (spi.spi_ack) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  pix_cnt_d = pix_cnt_q - PIX_CNT_W'(1);
                  if (pix_cnt_q == PIX_CNT_W'(1)) state_d = S_END;
               end
            end
         end
         S_END: begin
            spi_end = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            fill_done_o = 1'b1;
            fill_err_o  = err_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_INIT_REQ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_INIT_REQ;
         init_req_q <= 1'b0;
         x0_q       <= '0;
         x1c_q      <= '0;
         y0_q       <= '0;
         y1c_q      <= '0;
         color_q    <= '0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         phase_q    <= 1'b0;
         pix_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_req_q <= init_req_d;
         x0_q       <= x0_d;
         x1c_q      <= x1c_d;
         y0_q       <= y0_d;
         y1c_q      <= y1c_d;
         color_q    <= color_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
         phase_q    <= phase_d;
         pix_cnt_q  <= pix_cnt_d;
      end
   end

   assign init_req_o   = init_req_q;
   assign spi.spi_req  = spi_req;
   assign spi.spi_data = spi_data;
   assign spi.spi_dc   = spi_dc;
   assign spi.spi_end  = spi_end;

endmodule

// File: tb/tb_spi_tft_fill_ctrl.sv
// Self-checking bench for spi_tft_fill_ctrl: init model, randomly paced SPI
// byte sink, and a byte-stream reference model built from rectangle rules.
module tb_spi_tft_fill_ctrl;

   localparam int W        = 320;
   localparam int H        = 240;
   localparam int INIT_LEN = 3;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        init_req_o, init_ack_i, init_dc_i, init_spi_req_i, init_spi_end_i, init_spi_ack_o;
   logic [7:0]  init_data_i;
   logic        fill_req_i, ready_o, fill_done_o, fill_err_o;
   logic [15:0] fill_x0_i, fill_x1_i, fill_y0_i, fill_y1_i, fill_color_i;

   spi_tft_fill_ctrl_if spi_bus ();

   spi_tft_fill_ctrl #(
      .SCREEN_WIDTH  (16'd320),
      .SCREEN_HEIGHT (16'd240),
      .PIX_CNT_W     (18)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .init_req_o     (init_req_o),
      .init_ack_i     (init_ack_i),
      .init_data_i    (init_data_i),
      .init_dc_i      (init_dc_i),
      .init_spi_req_i (init_spi_req_i),
      .init_spi_end_i (init_spi_end_i),
      .init_spi_ack_o (init_spi_ack_o),
      .fill_req_i     (fill_req_i),
      .fill_x0_i      (fill_x0_i),
      .fill_x1_i      (fill_x1_i),
      .fill_y0_i      (fill_y0_i),
      .fill_y1_i      (fill_y1_i),
      .fill_color_i   (fill_color_i),
      .ready_o        (ready_o),
      .fill_done_o    (fill_done_o),
      .fill_err_o     (fill_err_o),
      .spi            (spi_bus.master)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_checks, n_errors;
   logic [8:0] obs_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] init_seq[INIT_LEN];
   int         cyc, n_end, last_end_cyc, n_done, n_init_req, n_init_fwd;
   bit         stray_en, ack_real, init_busy;
   int         init_idx, gap;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (spi_bus.spi_end) begin n_end++; last_end_cyc = cyc; end
      if (fill_done_o)    n_done++;
      if (init_req_o)     n_init_req++;
      if (init_spi_ack_o) n_init_fwd++;
   end

   // Init module model and SPI byte sink share one process so byte hand-off order is fixed.
   initial begin
      spi_bus.spi_ack = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            spi_bus.spi_ack = 1'b0;
            init_spi_req_i  = 1'b0;
            init_ack_i      = 1'b0;
            init_busy       = 1'b0;
         end else begin
            init_ack_i = 1'b0;
            if (spi_bus.spi_ack) begin
               spi_bus.spi_ack = 1'b0;
               if (ack_real && init_busy) begin
                  init_idx++;
                  if (init_idx == INIT_LEN) begin
                     init_busy      = 1'b0;
                     init_spi_req_i = 1'b0;
                     init_ack_i     = 1'b1;
                  end else begin
                     {init_dc_i, init_data_i} = init_seq[init_idx];
                  end
               end
            end
            if (init_req_o && !init_busy) begin
               for (int i = 0; i < INIT_LEN; i++)
                  init_seq[i] = {1'($urandom_range(0, 1)), 8'($urandom)};
               init_busy = 1'b1;
               init_idx  = 0;
               {init_dc_i, init_data_i} = init_seq[0];
               init_spi_req_i = 1'b1;
            end
            #1;
            if (spi_bus.spi_req) begin
               if (gap == 0) begin
                  obs_q.push_back({spi_bus.spi_dc, spi_bus.spi_data});
                  spi_bus.spi_ack = 1'b1;
                  ack_real        = 1'b1;
                  gap             = $urandom_range(0, 2);
               end else begin
                  gap--;
               end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
               spi_bus.spi_ack = 1'b1;
               ack_real        = 1'b0;
            end
         end
      end
   end

   task automatic push_window(input logic [7:0] cmd, input int a, input int b);
      logic [15:0] av, bv;
      av = 16'(a);
      bv = 16'(b);
      exp_q.push_back({1'b0, cmd});
      exp_q.push_back({1'b1, av[15:8]});
      exp_q.push_back({1'b1, av[7:0]});
      exp_q.push_back({1'b1, bv[15:8]});
      exp_q.push_back({1'b1, bv[7:0]});
   endtask

   task automatic build_expect(input int x0, input int x1, input int y0, input int y1,
                               input logic [15:0] color, output bit rej);
      int x1c, y1c, npix;
      exp_q.delete();
      x1c = (x1 > W - 1) ? W - 1 : x1;
      y1c = (y1 > H - 1) ? H - 1 : y1;
      rej = (x0 > x1c) || (y0 > y1c) || (x0 >= W) || (y0 >= H);
      if (rej) return;
      push_window(8'h2A, x0, x1c);
      push_window(8'h2B, y0, y1c);
      exp_q.push_back({1'b0, 8'h2C});
      npix = (x1c - x0 + 1) * (y1c - y0 + 1);
      for (int p = 0; p < npix; p++) begin
         exp_q.push_back({1'b1, color[15:8]});
         exp_q.push_back({1'b1, color[7:0]});
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready_o && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      check_eq({tag, "_ready"}, 32'(ready_o), 32'd1);
   endtask

   task automatic drive_fill(input int x0, input int x1, input int y0, input int y1,
                             input logic [15:0] color);
      fill_x0_i    = 16'(x0);
      fill_x1_i    = 16'(x1);
      fill_y0_i    = 16'(y0);
      fill_y1_i    = 16'(y1);
      fill_color_i = color;
      fill_req_i   = 1'b1;
   endtask

   task automatic check_init_bytes(input string tag);
      check_eq({tag, "_nbytes"}, 32'(obs_q.size()), 32'(INIT_LEN));
      for (int i = 0; i < INIT_LEN && i < obs_q.size(); i++)
         check_eq($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(init_seq[i]));
   endtask

   // Entered on the negedge right after the accepting clock edge.
   task automatic finish_fill(input string tag, input bit rej, input bit junk, input int end0);
      int n, bound, m;
      if (rej) begin
         check_eq({tag, "_rej_done"}, 32'(fill_done_o), 32'd1);
         check_eq({tag, "_rej_err"},  32'(fill_err_o),  32'd1);
         check_eq({tag, "_rej_req"},  32'(spi_bus.spi_req), 32'd0);
      end else begin
         check_eq({tag, "_acc_req"},   32'(spi_bus.spi_req), 32'd1);
         check_eq({tag, "_acc_ready"}, 32'(ready_o), 32'd0);
      end
      n = 0;
      bound = 40 + 4 * exp_q.size();
      while (!fill_done_o && n < bound) begin
         if (junk) begin
            fill_req_i   = 1'($urandom_range(0, 1));
            fill_x0_i    = 16'($urandom);
            fill_x1_i    = 16'($urandom);
            fill_color_i = 16'($urandom);
         end else begin
            fill_req_i = 1'b0;
         end
         @(negedge sys_clk);
         n++;
      end
      fill_req_i = 1'b0;
      check_eq({tag, "_done"}, 32'(fill_done_o), 32'd1);
      check_eq({tag, "_err"},  32'(fill_err_o),  32'(rej));
      check_eq({tag, "_ends"}, 32'(n_end - end0), rej ? 32'd0 : 32'd1);
      if (!rej) check_eq({tag, "_end_to_done"}, 32'(cyc - last_end_cyc), 32'd1);
      check_eq({tag, "_nbytes"}, 32'(obs_q.size()), 32'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++)
         check_eq($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      @(negedge sys_clk);
      check_eq({tag, "_done_pulse"}, 32'(fill_done_o), 32'd0);
      check_eq({tag, "_idle_ready"}, 32'(ready_o), 32'd1);
   endtask

   task automatic run_fill(input string tag, input int x0, input int x1, input int y0,
                           input int y1, input logic [15:0] color, input bit junk);
      bit rej;
      int end0;
      wait_ready(tag);
      build_expect(x0, x1, y0, y1, color, rej);
      obs_q.delete();
      end0 = n_end;
      drive_fill(x0, x1, y0, y1, color);
      @(negedge sys_clk);
      fill_req_i = 1'b0;
      finish_fill(tag, rej, junk, end0);
   endtask

   initial begin
      bit rej;
      int end0, done0, ir0, fwd0, n;
      int x0, x1, y0, y1;

      sys_rst_n      = 1'b0;
      init_ack_i     = 1'b0;
      init_data_i    = 8'h00;
      init_dc_i      = 1'b0;
      init_spi_req_i = 1'b0;
      init_spi_end_i = 1'b0;
      fill_req_i     = 1'b0;
      drive_fill(0, 0, 0, 0, 16'h0000);
      fill_req_i     = 1'b0;
      stray_en       = 1'b0;

      repeat (3) @(negedge sys_clk);
      check_eq("rst_ready",    32'(ready_o),          32'd0);
      check_eq("rst_done",     32'(fill_done_o),      32'd0);
      check_eq("rst_err",      32'(fill_err_o),       32'd0);
      check_eq("rst_spi_req",  32'(spi_bus.spi_req),  32'd0);
      check_eq("rst_spi_end",  32'(spi_bus.spi_end),  32'd0);
      check_eq("rst_init_req", 32'(init_req_o),       32'd0);
      check_eq("rst_init_ack", 32'(init_spi_ack_o),   32'd0);
      check_eq("rst_data",     32'(spi_bus.spi_data), 32'd0);
      check_eq("rst_dc",       32'(spi_bus.spi_dc),   32'd0);

      // Request held through init: must be taken only once ready_o rises.
      drive_fill(5, 5, 7, 7, 16'hF800);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      wait_ready("init");
      check_eq("init_req_pulses", 32'(n_init_req), 32'd1);
      check_eq("init_ack_fwd",    32'(n_init_fwd), 32'(INIT_LEN));
      check_init_bytes("init");
      build_expect(5, 5, 7, 7, 16'hF800, rej);
      obs_q.delete();
      end0 = n_end;
      @(negedge sys_clk);
      finish_fill("fill_5_7", rej, 1'b1, end0);

      stray_en = 1'b1;
      run_fill("clip_x",      300, 400,  0,    10, 16'h1234, 1'b0);
      run_fill("rej_x",        10,   5,  0,     0, 16'hFFFF, 1'b0);
      run_fill("clip_corner", 319, 500, 239, 65535, 16'hA5C3, 1'b1);
      run_fill("rej_x0_edge", 320, 325,  0,     3, 16'h0F0F, 1'b0);
      run_fill("rej_y0_edge",   0,   3, 240,  250, 16'h0F0F, 1'b0);
      run_fill("origin",        0,   0,  0,     0, 16'h8001, 1'b0);
      run_fill("rej_y",         3,   4,  9,     8, 16'h0001, 1'b0);

      for (int k = 0; k < 10; k++) begin
         x0 = ($urandom_range(0, 1) == 1) ? $urandom_range(310, 325) : $urandom_range(0, 330);
         x1 = x0 + $urandom_range(0, 6) - (($urandom_range(0, 4) == 0) ? 3 : 0);
         y0 = ($urandom_range(0, 1) == 1) ? $urandom_range(232, 244) : $urandom_range(0, 245);
         y1 = y0 + $urandom_range(0, 6) - (($urandom_range(0, 4) == 0) ? 3 : 0);
         if (x1 < 0) x1 = 0;
         if (y1 < 0) y1 = 0;
         run_fill($sformatf("rnd%0d", k), x0, x1, y0, y1, 16'($urandom), 1'($urandom_range(0, 1)));
      end

      // Full-screen fill interrupted by reset partway through the pixel stream.
      wait_ready("full");
      build_expect(0, 319, 0, 239, 16'h07E0, rej);
      obs_q.delete();
      done0 = n_done;
      drive_fill(0, 319, 0, 239, 16'h07E0);
      @(negedge sys_clk);
      fill_req_i = 1'b0;
      check_eq("full_acc_req", 32'(spi_bus.spi_req), 32'd1);
      n = 0;
      while (obs_q.size() < 40 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      check_eq("full_prefix_len", 32'(obs_q.size() >= 40), 32'd1);
      for (int i = 0; i < 40 && i < obs_q.size(); i++)
         check_eq($sformatf("full_byte%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
      check_eq("full_req_before_rst", 32'(spi_bus.spi_req), 32'd1);
      #2 sys_rst_n = 1'b0;
      #1;
      check_eq("mid_rst_req",      32'(spi_bus.spi_req), 32'd0);
      check_eq("mid_rst_end",      32'(spi_bus.spi_end), 32'd0);
      check_eq("mid_rst_ready",    32'(ready_o),         32'd0);
      check_eq("mid_rst_init_req", 32'(init_req_o),      32'd0);
      check_eq("mid_rst_done",     32'(fill_done_o),     32'd0);
      ir0  = n_init_req;
      fwd0 = n_init_fwd;
      stray_en = 1'b0;
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      obs_q.delete();
      @(negedge sys_clk);
      wait_ready("reinit");
      check_eq("reinit_req_pulses", 32'(n_init_req - ir0), 32'd1);
      check_eq("reinit_ack_fwd",    32'(n_init_fwd - fwd0), 32'(INIT_LEN));
      check_eq("reinit_no_done",    32'(n_done - done0), 32'd0);
      check_init_bytes("reinit");

      stray_en = 1'b1;
      run_fill("after_rst", 100, 103, 50, 51, 16'hBEEF, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
